// File: rtl/mmcm_drp_sequencer_pkg.sv
// Shared types and constants for the MMCM DRP reconfiguration sequencer.
// Table entries pack as {drp_addr, keep_mask, data}, with the address field at the top.
package mmcm_drp_sequencer_pkg;

    localparam int unsigned DRP_ADDR_W = 7;
    localparam int unsigned DRP_DATA_W = 16;
    localparam int unsigned TBL_W      = DRP_ADDR_W + 2 * DRP_DATA_W;

    localparam int unsigned DATA_LSB = 0;
    localparam int unsigned KEEP_LSB = DATA_LSB + DRP_DATA_W;
    localparam int unsigned ADDR_LSB = KEEP_LSB + DRP_DATA_W;

    typedef struct packed {
        logic [DRP_ADDR_W-1:0] addr;
        logic [DRP_DATA_W-1:0] keep_mask;
        logic [DRP_DATA_W-1:0] data;
    } tbl_entry_t;

    typedef enum logic [3:0] {
        StPorHold,
        StIdle,
        StAssertRst,
        StRdReq,
        StRdWait,
        StWrReq,
        StWrWait,
        StRelease,
        StLockWait
    } state_e;

    // Bits set in keep_mask retain the value read back from the MMCM.
    function automatic logic [DRP_DATA_W-1:0] rmw_merge(input logic [DRP_DATA_W-1:0] rd_data,
                                                        input logic [DRP_DATA_W-1:0] keep_mask,
                                                        input logic [DRP_DATA_W-1:0] wr_data);
        return (rd_data & keep_mask) | (wr_data & ~keep_mask);
    endfunction

endpackage

// File: rtl/mmcm_drp_table.sv
// Reconfiguration table: one synchronous write port and one asynchronous read port.
// A read of the entry being written returns the incoming data.
module mmcm_drp_table
    import mmcm_drp_sequencer_pkg::*;
#(
    parameter int unsigned NUM_ENTRIES = 23,
    parameter int unsigned IDX_W       = 5
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [IDX_W-1:0] waddr_i,
    input  logic [TBL_W-1:0] wdata_i,
    input  logic [IDX_W-1:0] raddr_i,
    output logic [TBL_W-1:0] rdata_o
);

    localparam logic [IDX_W-1:0] NumEntriesIdx = IDX_W'(NUM_ENTRIES);

    logic [TBL_W-1:0] mem_q [NUM_ENTRIES];
    logic             wr_en;

    assign wr_en = we_i && (waddr_i < NumEntriesIdx);

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        rdata_o = '0;
        if (wr_en && (waddr_i == raddr_i)) begin
            rdata_o = wdata_i;
        end else if (raddr_i < NumEntriesIdx) begin
            rdata_o = mem_q[raddr_i];
        end
    end

endmodule

// File: rtl/mmcm_drp_sequencer.sv
// Runtime MMCM reconfiguration: holds the MMCM in reset, read-modify-writes a table of DRP
// registers, releases reset and waits for lock. All outputs are registered.
module mmcm_drp_sequencer
    import mmcm_drp_sequencer_pkg::*;
#(
    parameter int unsigned NUM_ENTRIES  = 23,
    parameter int unsigned IDX_W        = 5,
    parameter int unsigned RST_CYCLES   = 4,
    parameter int unsigned DRDY_TIMEOUT = 64,
    parameter int unsigned LOCK_TIMEOUT = 65535
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  tblWe,
    input  logic [IDX_W-1:0]      tblAddr,
    input  logic [TBL_W-1:0]      tblData,
    input  logic                  startValid,
    input  logic [IDX_W-1:0]      startCount,
    output logic                  startReady,
    output logic [DRP_ADDR_W-1:0] drpAddr,
    output logic [DRP_DATA_W-1:0] drpDi,
    output logic                  drpDen,
    output logic                  drpDwe,
    input  logic [DRP_DATA_W-1:0] drpDo,
    input  logic                  drpRdy,
    output logic                  mmcmRst,
    input  logic                  mmcmLocked,
    output logic                  done,
    output logic                  error,
    output logic                  locked
);

    localparam logic [IDX_W-1:0] NumEntriesIdx = IDX_W'(NUM_ENTRIES);
    localparam logic [15:0]      RstLast       = 16'(RST_CYCLES - 1);
    localparam logic [15:0]      DrdyLast      = 16'(DRDY_TIMEOUT - 1);
    localparam logic [15:0]      LockLast      = 16'(LOCK_TIMEOUT - 1);

    state_e                state_q, state_d;
    logic [15:0]           timer_q, timer_d, timer_inc;
    logic [IDX_W-1:0]      idx_q, idx_d, count_q, count_d, rd_idx;
    logic                  rst_q, rst_d;
    logic                  den_q, den_d;
    logic                  dwe_q, dwe_d;
    logic [DRP_ADDR_W-1:0] addr_q, addr_d;
    logic [DRP_DATA_W-1:0] di_q, di_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic                  ready_q, ready_d;
    logic [1:0]            lock_sync_q, lock_sync_d;
    logic                  tbl_we;
    logic [TBL_W-1:0]      rd_raw;
    tbl_entry_t            rd_entry;

    // The table is only writable while idle, so it is stable for a whole sequence.
    assign tbl_we = tblWe && (state_q == StIdle);

    // Leaving WR_WAIT the next DEN needs the following entry's address.
    assign rd_idx = (state_q == StWrWait) ? idx_q + IDX_W'(1) : idx_q;

    mmcm_drp_table #(
        .NUM_ENTRIES(NUM_ENTRIES),
        .IDX_W      (IDX_W)
    ) u_table (
        .clk_i  (CLK),
        .we_i   (tbl_we),
        .waddr_i(tblAddr),
        .wdata_i(tblData),
        .raddr_i(rd_idx),
        .rdata_o(rd_raw)
    );

    assign rd_entry.addr      = rd_raw[ADDR_LSB +: DRP_ADDR_W];
    assign rd_entry.keep_mask = rd_raw[KEEP_LSB +: DRP_DATA_W];
    assign rd_entry.data      = rd_raw[DATA_LSB +: DRP_DATA_W];

    assign timer_inc = (timer_q == 16'hFFFF) ? timer_q : timer_q + 16'd1;

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_inc;
        idx_d       = idx_q;
        count_d     = count_q;
        rst_d       = rst_q;
        den_d       = 1'b0;
        dwe_d       = 1'b0;
        addr_d      = addr_q;
        di_d        = di_q;
        done_d      = 1'b0;
        error_d     = error_q;
        ready_d     = ready_q;
        lock_sync_d = {lock_sync_q[0], mmcmLocked};

        case (state_q)
            StPorHold: begin
                if (timer_q == RstLast) begin
                    rst_d   = 1'b0;
                    ready_d = 1'b1;
                    state_d = StIdle;
                end
            end
            StIdle: begin
                if (startValid) begin
                    if ((startCount == '0) || (startCount > NumEntriesIdx)) begin
                        error_d = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        error_d = 1'b0;
                        count_d = startCount;
                        idx_d   = '0;
                        timer_d = '0;
                        rst_d   = 1'b1;
                        ready_d = 1'b0;
                        state_d = StAssertRst;
                    end
                end
            end
            StAssertRst: begin
                if (timer_q == RstLast) begin
                    den_d   = 1'b1;
                    addr_d  = rd_entry.addr;
                    state_d = StRdReq;
                end
            end
            StRdReq: begin
                timer_d = '0;
                state_d = StRdWait;
            end
            StRdWait: begin
                if (drpRdy) begin
                    di_d    = rmw_merge(drpDo, rd_entry.keep_mask, rd_entry.data);
                    den_d   = 1'b1;
                    dwe_d   = 1'b1;
                    state_d = StWrReq;
                end else if (timer_q == DrdyLast) begin
                    error_d = 1'b1;
                    state_d = StRelease;
                end
            end
            StWrReq: begin
                timer_d = '0;
                state_d = StWrWait;
            end
            StWrWait: begin
                if (drpRdy) begin
                    if (idx_q == count_q - IDX_W'(1)) begin
                        state_d = StRelease;
                    end else begin
                        idx_d   = rd_idx;
                        den_d   = 1'b1;
                        addr_d  = rd_entry.addr;
                        state_d = StRdReq;
                    end
                end else if (timer_q == DrdyLast) begin
                    error_d = 1'b1;
                    state_d = StRelease;
                end
            end
            StRelease: begin
                rst_d   = 1'b0;
                timer_d = '0;
                state_d = StLockWait;
            end
            StLockWait: begin
                if (lock_sync_q[1]) begin
                    done_d  = 1'b1;
                    ready_d = 1'b1;
                    state_d = StIdle;
                end else if (timer_q == LockLast) begin
                    error_d = 1'b1;
                    done_d  = 1'b1;
                    ready_d = 1'b1;
                    state_d = StIdle;
                end
            end
            default: begin
                rst_d   = 1'b1;
                ready_d = 1'b0;
                timer_d = '0;
                state_d = StPorHold;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= StPorHold;
            timer_q     <= '0;
            idx_q       <= '0;
            count_q     <= '0;
            rst_q       <= 1'b1;
            den_q       <= 1'b0;
            dwe_q       <= 1'b0;
            addr_q      <= '0;
            di_q        <= '0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            ready_q     <= 1'b0;
            lock_sync_q <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            idx_q       <= idx_d;
            count_q     <= count_d;
            rst_q       <= rst_d;
            den_q       <= den_d;
            dwe_q       <= dwe_d;
            addr_q      <= addr_d;
            di_q        <= di_d;
            done_q      <= done_d;
            error_q     <= error_d;
            ready_q     <= ready_d;
            lock_sync_q <= lock_sync_d;
        end
    end

    assign startReady = ready_q;
    assign drpAddr    = addr_q;
    assign drpDi      = di_q;
    assign drpDen     = den_q;
    assign drpDwe     = dwe_q;
    assign mmcmRst    = rst_q;
    assign done       = done_q;
    assign error      = error_q;
    assign locked     = lock_sync_q[1];

endmodule
